// File: rtl/nco_rom_pkg.sv
// Shared types and helpers for the NCO quarter-wave ROM arbiter.
// Holds the quadrant type, the phase-fold function and the response ID width.
package nco_rom_pkg;

    typedef logic [1:0] quadrant_t;

    // Fold works on a fixed wide index; callers keep only their low ADDR_W bits.
    localparam int FOLD_AW = 16;

    typedef struct packed {
        logic [FOLD_AW-1:0] addr;
        logic               neg;
    } fold_t;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam int N_REQ_DEF = 4;
    localparam int ID_W      = id_width(N_REQ_DEF);

    // Cosine is sine advanced by one quadrant; odd quadrants read the table mirrored.
    function automatic fold_t fold(input quadrant_t q, input logic cos_sel,
                                   input logic [FOLD_AW-1:0] idx);
        quadrant_t qq;
        fold_t     f;
        qq     = q + quadrant_t'(cos_sel);
        f.addr = qq[0] ? ~idx : idx;
        f.neg  = qq[1];
        return f;
    endfunction

endpackage

// File: rtl/nco_rsp_fifo.sv
// First-word-fall-through response FIFO; the head is visible while valid_o is high.
// Overflow protection is the writer's job (credit counter in the arbiter).
module nco_rsp_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rd_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    assign valid_o   = (wr_ptr != rd_ptr);
    assign rd_data_o = valid_o ? mem[rd_ptr[PW-1:0]] : '0;

    // NOTE: storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_ptr[PW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en_i && valid_o) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nco_rom_arbiter.sv
// Round-robin sharing of one quarter-wave sin/cos ROM among N_REQ NCO channels.
// Define NCO_ROM_ARB_PRIO0_EN to give channel 0 absolute priority over the others.
module nco_rom_arbiter
    import nco_rom_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int FIFO_D  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*PHASE_W-1:0]   req_phase_i,
    input  logic [N_REQ-1:0]           req_cos_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [ADDR_W-1:0]          rom_addr_o,
    output logic                       rom_en_o,
    input  logic [DATA_W-1:0]          rom_data_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_data_o,
    output logic [$clog2(N_REQ)-1:0]   rsp_id_o
);

    localparam int IW = id_width(N_REQ);
    localparam int CW = $clog2(FIFO_D + 1);

    logic [PHASE_W-1:0] phase_arr [N_REQ];
    logic [IW-1:0]      rr_q;
    logic [CW-1:0]      cred_q;
    logic               pop;
    logic               slot_free;
    logic               grant;
    logic [IW-1:0]      grant_id;
    logic               rr_upd;
    int                 ch;
    logic [IW-1:0]      ch_idx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign phase_arr[k] = req_phase_i[k*PHASE_W +: PHASE_W];
    end

    assign pop       = rsp_valid_o & rsp_ready_i;
    // A pop frees a FIFO slot now, so it may fund a grant in the same cycle.
    assign slot_free = (cred_q != '0) | pop;

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        rr_upd   = 1'b0;
        ch       = 0;
        ch_idx   = '0;
        if (slot_free) begin
`ifdef NCO_ROM_ARB_PRIO0_EN
            if (req_valid_i[0]) begin
                grant = 1'b1;
            end
`endif
            for (int k = 0; k < N_REQ; k++) begin
                ch     = (int'(rr_q) + k) % N_REQ;
                ch_idx = IW'(ch);
                if (!grant && req_valid_i[ch_idx]) begin
                    grant    = 1'b1;
                    grant_id = ch_idx;
                    rr_upd   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        req_ready_o           = '0;
        req_ready_o[grant_id] = grant;
    end

    logic [PHASE_W-1:0] sel_phase;
    fold_t              fold_res;
    logic               unused_bits;

    assign sel_phase   = phase_arr[grant_id];
    assign fold_res    = fold(sel_phase[PHASE_W-1 -: 2], req_cos_i[grant_id],
                              FOLD_AW'(sel_phase[PHASE_W-3 -: ADDR_W]));
    assign unused_bits = ^{sel_phase[PHASE_W-ADDR_W-3:0], fold_res.addr[FOLD_AW-1:ADDR_W]};

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            cred_q <= CW'(FIFO_D);
        end else begin
            if (rr_upd) begin
                rr_q <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            case ({grant, pop})
                2'b10:   cred_q <= cred_q - 1'b1;
                2'b01:   cred_q <= cred_q + 1'b1;
                default: cred_q <= cred_q;
            endcase
        end
    end

    logic          s1_neg;
    logic [IW-1:0] s1_id;
    logic          s2_valid;
    logic          s2_neg;
    logic [IW-1:0] s2_id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rom_en_o   <= 1'b0;
            rom_addr_o <= '0;
            s1_neg     <= 1'b0;
            s1_id      <= '0;
            s2_valid   <= 1'b0;
            s2_neg     <= 1'b0;
            s2_id      <= '0;
        end else begin
            rom_en_o <= grant;
            if (grant) begin
                rom_addr_o <= fold_res.addr[ADDR_W-1:0];
                s1_neg     <= fold_res.neg;
                s1_id      <= grant_id;
            end
            s2_valid <= rom_en_o;
            s2_neg   <= s1_neg;
            s2_id    <= s1_id;
        end
    end

    logic [DATA_W-1:0]    s2_data;
    logic [IW+DATA_W-1:0] fifo_head;

    assign s2_data = s2_neg ? -rom_data_i : rom_data_i;

    nco_rsp_fifo #(
        .WIDTH (IW + DATA_W),
        .DEPTH (FIFO_D)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (s2_valid),
        .wr_data_i ({s2_id, s2_data}),
        .rd_en_i   (rsp_ready_i),
        .valid_o   (rsp_valid_o),
        .rd_data_o (fifo_head)
    );

    assign rsp_data_o = fifo_head[DATA_W-1:0];
    assign rsp_id_o   = fifo_head[IW+DATA_W-1:DATA_W];

endmodule

// File: tb/tb_nco_rom_arbiter.sv
// Scoreboard bench for nco_rom_arbiter: grants push expected responses, a monitor pops and compares.
// Expected grant order follows NCO_ROM_ARB_PRIO0_EN when it is defined.
module tb_nco_rom_arbiter;

    localparam int N_REQ   = 4;
    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int FIFO_D  = 4;
    localparam int IW      = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [N_REQ-1:0]         req_valid_i;
    logic [N_REQ*PHASE_W-1:0] req_phase_i;
    logic [N_REQ-1:0]         req_cos_i;
    logic [N_REQ-1:0]         req_ready_o;
    logic [ADDR_W-1:0]        rom_addr_o;
    logic                     rom_en_o;
    logic [DATA_W-1:0]        rom_data_i = '0;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DATA_W-1:0]        rsp_data_o;
    logic [IW-1:0]            rsp_id_o;

    typedef struct {
        logic [IW-1:0]     id;
        logic [DATA_W-1:0] data;
        int                t_grant;
    } exp_t;

    exp_t              sb_q[$];
    int                grant_log[$];
    logic [DATA_W-1:0] exp_tbl [N_REQ];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    int                rsp_seen = 0;
    bit                lat_check = 1'b0;

    nco_rom_arbiter #(
        .N_REQ(N_REQ), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_D(FIFO_D)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_phase_i (req_phase_i),
        .req_cos_i   (req_cos_i),
        .req_ready_o (req_ready_o),
        .rom_addr_o  (rom_addr_o),
        .rom_en_o    (rom_en_o),
        .rom_data_i  (rom_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Test ROM: entry 0 is 0x0032, other entries are positive and distinct per address.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return (a == '0) ? 16'h0032 : {1'b0, a, 5'h1F};
    endfunction

    always @(posedge clk_i) begin
        if (rom_en_o) rom_data_i <= rom_word(rom_addr_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni === 1'b1) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (req_valid_i[k] && req_ready_o[k]) begin
                    sb_q.push_back('{id: IW'(k), data: exp_tbl[k], t_grant: cyc});
                    grant_log.push_back(k);
                end
            end
            if (rsp_valid_o) rsp_seen++;
            if (rsp_valid_o && rsp_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_id", 32'(rsp_id_o), 32'(e.id));
                    check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                    if (lat_check) check("rsp_latency", cyc - e.t_grant, 3);
                end
            end
        end
    end

    task automatic set_chan(input int k, input logic [31:0] phase, input logic cos_sel,
                            input logic [DATA_W-1:0] exp_data);
        req_phase_i[k*PHASE_W +: PHASE_W] = phase;
        req_cos_i[k] = cos_sel;
        exp_tbl[k]   = exp_data;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni      = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        sb_q.delete();
        grant_log.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_drain"}, sb_q.size(), 0);
    endtask

    task automatic single(input string name, input logic [31:0] phase, input logic cos_sel,
                          input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] exp_data);
        int n = 0;
        @(posedge clk_i); #1;
        set_chan(0, phase, cos_sel, exp_data);
        req_valid_i[0] = 1'b1;
        @(negedge clk_i);
        while (!req_ready_o[0] && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_grant"}, 32'(req_ready_o[0]), 32'd1);
        @(posedge clk_i); #1 req_valid_i[0] = 1'b0;
        @(negedge clk_i);
        check({name, "_rom_en"}, 32'(rom_en_o), 32'd1);
        check({name, "_rom_addr"}, 32'(rom_addr_o), 32'(exp_addr));
        wait_drain(name);
        check({name, "_rom_idle"}, 32'(rom_en_o), 32'd0);
        check({name, "_addr_hold"}, 32'(rom_addr_o), 32'(exp_addr));
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        int exp_ch;
        rst_ni      = 1'b1;
        req_valid_i = '0;
        req_cos_i   = '0;
        req_phase_i = '0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < N_REQ; k++) exp_tbl[k] = '0;
        #2 rst_ni = 1'b0;

        // Reset values, then a request already valid when reset releases.
        @(negedge clk_i);
        check("rst_rom_addr", 32'(rom_addr_o), 32'd0);
        check("rst_rom_en", 32'(rom_en_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", 32'(rsp_data_o), 32'd0);
        check("rst_rsp_id", 32'(rsp_id_o), 32'd0);
        set_chan(0, 32'h0000_0000, 1'b0, 16'h0032);
        req_valid_i[0] = 1'b1;
        lat_check = 1'b1;
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("ready_after_release", 32'(req_ready_o), 32'h1);
        @(posedge clk_i); #1 req_valid_i[0] = 1'b0;
        @(negedge clk_i);
        check("first_rom_en", 32'(rom_en_o), 32'd1);
        check("first_rom_addr", 32'(rom_addr_o), 32'h000);
        wait_drain("first");

        single("sin_q0",   32'h0000_0000, 1'b0, 10'h000, 16'h0032);
        single("sin_q1",   32'h4000_0000, 1'b0, 10'h3FF, 16'h7FFF);
        single("sin_q2",   32'h8000_0000, 1'b0, 10'h000, 16'hFFCE);
        single("sin_idx1", 32'h0010_FFFF, 1'b0, 10'h001, 16'h003F);
        single("sin_q3",   32'hC030_0000, 1'b0, 10'h3FC, 16'h8061);
        single("cos_q0",   32'h0000_0000, 1'b1, 10'h3FF, 16'h7FFF);
        single("cos_q3",   32'hC000_0000, 1'b1, 10'h000, 16'h0032);
        single("cos_q1",   32'h4000_0000, 1'b1, 10'h000, 16'hFFCE);
        lat_check = 1'b0;

        // All channels streaming with the consumer always ready.
        do_reset();
        set_chan(0, 32'h0000_0000, 1'b0, 16'h0032);
        set_chan(1, 32'h8000_0000, 1'b0, 16'hFFCE);
        set_chan(2, 32'h4000_0000, 1'b0, 16'h7FFF);
        set_chan(3, 32'hC000_0000, 1'b0, 16'h8001);
        @(posedge clk_i); #1 req_valid_i = 4'hF;
        run_cycles(8);
        @(posedge clk_i); #1 req_valid_i = '0;
        check("stream_grants", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            check($sformatf("stream_order%0d", i), grant_log[i], i % 4);
        end
        wait_drain("stream");

        // Backpressure: credits cap grants at the FIFO depth; one pop funds one grant.
        do_reset();
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1 req_valid_i = 4'hF;
        run_cycles(8);
        check("bp_grants", grant_log.size(), 4);
        check("bp_ready_low", 32'(req_ready_o), 32'h0);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check($sformatf("bp_order%0d", i), grant_log[i], i);
        end
        @(posedge clk_i); #1 rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_pop_grant", 32'(req_ready_o), 32'h1);
        @(posedge clk_i); #1 rsp_ready_i = 1'b0;
        run_cycles(3);
        check("bp_one_more", grant_log.size(), 5);
        check("bp_ready_low2", 32'(req_ready_o), 32'h0);
        @(posedge clk_i); #1;
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        wait_drain("bp");

        // Reset with two responses queued and two still in the pipeline.
        do_reset();
        rsp_ready_i = 1'b0;
        @(posedge clk_i); #1 req_valid_i[0] = 1'b1;
        run_cycles(4);
        check("mid_queued", 32'(rsp_valid_o), 32'd1);
        @(posedge clk_i); #1;
        rst_ni      = 1'b0;
        req_valid_i = '0;
        sb_q.delete();
        grant_log.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        rsp_seen    = 0;
        run_cycles(10);
        check("mid_no_rsp", rsp_seen, 0);
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        req_valid_i = 4'hF;
        run_cycles(8);
        check("mid_cred_full", grant_log.size(), 4);
        @(posedge clk_i); #1;
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        wait_drain("mid");

        // Channels 0 and 2 contending.
        do_reset();
        @(posedge clk_i); #1 req_valid_i = 4'b0101;
        run_cycles(6);
        @(posedge clk_i); #1 req_valid_i = '0;
        check("prio_grants", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
`ifdef NCO_ROM_ARB_PRIO0_EN
            exp_ch = 0;
`else
            exp_ch = (i % 2 == 0) ? 0 : 2;
`endif
            check($sformatf("prio_order%0d", i), grant_log[i], exp_ch);
        end
        wait_drain("prio");

        run_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
